spi_master_byte: RTL and testbench

//  Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0, MSB first); the initiator counterpart of spi_Interface.
//  The FPGA uses it to drive on-board SPI targets itself: the serial SRAM on sram_spi_* and PCM9211/PCM1792 control.
//  One transaction is xfer_len bytes with CS held low throughout.
//  TX bytes are pulled from a streaming source; every received byte is pushed out with a one-cycle valid.

---
 rtl/audipus_spi_pkg.sv | 16 +
 rtl/spi_sclk_gen.sv | 47 ++++
 rtl/spi_master_byte.sv | 177 +++++++++++++++++
 tb/tb_spi_master_byte.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audipus_spi_pkg.sv
// rtl/audipus_spi_pkg.sv - shared SPI state encoding and clock mode constants
package audipus_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Mode 0: SCLK idles low, data sampled on the leading edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period divider with leading/trailing edge strobes
module spi_sclk_gen
    import audipus_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             half_end;

    // Strobes are asserted in the cycle whose closing edge toggles SCLK
    assign half_end = en && (cnt_q == CNT_LAST);
    assign rise_stb = half_end && (sclk_q == SPI_CPOL);
    assign fall_stb = half_end && (sclk_q != SPI_CPOL);
    assign sclk     = sclk_q;

    always_comb begin
        cnt_d  = '0;
        sclk_d = SPI_CPOL;
        if (en) begin
            cnt_d  = half_end ? '0 : cnt_q + 1'b1;
            sclk_d = half_end ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - byte-oriented mode-0 SPI master with streaming TX and pulsed RX
module spi_master_byte
    import audipus_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int WAIT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLK_DIV - 1);

    spi_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cs_n_q, cs_n_d;

    logic rise_stb, fall_stb, sample_stb, shift_stb;
    logic start_ok, wait_last, last_byte, byte_end;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_SHIFT),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sclk     (spi_sclk)
    );

    assign sample_stb = SPI_CPHA ? fall_stb : rise_stb;
    assign shift_stb  = SPI_CPHA ? rise_stb : fall_stb;
    assign start_ok   = start && (xfer_len != '0);
    assign wait_last  = (wait_q == WAIT_LAST);
    assign last_byte  = (byte_cnt_q == LEN_W'(1));
    assign byte_end   = shift_stb && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)              state_d = ST_SETUP;
            ST_SETUP: if (wait_last)             state_d = ST_SHIFT;
            ST_SHIFT: if (byte_end && last_byte) state_d = ST_HOLD;
            ST_HOLD:  if (wait_last)             state_d = ST_GAP;
            ST_GAP:   if (wait_last)             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_d     = '0;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    byte_cnt_d = xfer_len;
                    bit_cnt_d  = 3'd0;
                    tx_sr_d    = tx_data;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (!wait_last) wait_d = wait_q + 1'b1;
            end
            ST_SHIFT: begin
                if (sample_stb) rx_sr_d = {rx_sr_q[6:0], spi_miso};
                if (shift_stb) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rd_data_d  = rx_sr_q;
                        rd_valid_d = 1'b1;
                        // Counts down to zero on the last byte and stops there
                        byte_cnt_d = byte_cnt_q - 1'b1;
                        if (!last_byte) begin
                            tx_sr_d    = tx_data;
                            tx_ready_d = 1'b1;
                        end
                    end else begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (wait_last) cs_n_d = 1'b1;
                else           wait_d = wait_q + 1'b1;
            end
            ST_GAP: begin
                if (wait_last) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q     <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            wait_q     <= wait_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = tx_sr_q[7];

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - scoreboard bench for spi_master_byte at CLK_DIV 4 and 2
module tb_spi_master_byte;

    localparam int DA = 4;
    localparam int DB = 2;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          a_start, a_tx_ready, a_rd_valid, a_busy, a_done;
    logic [LW-1:0] a_len;
    logic [7:0]    a_tx_data, a_rd_data;
    logic          a_cs_n, a_sclk, a_mosi, a_miso;
    logic          a_loop, tgt_miso;

    logic          b_start, b_tx_ready, b_rd_valid, b_busy, b_done;
    logic [LW-1:0] b_len;
    logic [7:0]    b_tx_data, b_rd_data;
    logic          b_cs_n, b_sclk, b_mosi, b_miso;

    assign a_miso = a_loop ? a_mosi : tgt_miso;
    assign b_miso = b_mosi;

    spi_master_byte #(.CLK_DIV(DA), .LEN_W(LW)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .xfer_len(a_len),
        .tx_data(a_tx_data), .tx_ready(a_tx_ready), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .busy(a_busy), .done(a_done),
        .spi_cs_n(a_cs_n), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso)
    );

    spi_master_byte #(.CLK_DIV(DB), .LEN_W(LW)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .xfer_len(b_len),
        .tx_data(b_tx_data), .tx_ready(b_tx_ready), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .busy(b_busy), .done(b_done),
        .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_src[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] obs_rx[$];
    logic       obs_mosi[$];
    int r_lat, r_tx, r_rises, r_cs_rise;

    // Mode-0 target: presents bit7 when CS falls, shifts on each SCLK fall
    logic [7:0] resp [3];
    logic [7:0] tgt_sr;
    int         tgt_bits, tgt_idx;
    assign tgt_miso = tgt_sr[7];

    always @(negedge a_cs_n) begin
        tgt_idx  = 0;
        tgt_bits = 0;
        tgt_sr   = resp[0];
    end

    always @(negedge a_sclk) begin
        if (a_cs_n === 1'b0) begin
            tgt_bits++;
            if (tgt_bits == 8) begin
                tgt_bits = 0;
                tgt_idx++;
                tgt_sr = (tgt_idx < 3) ? resp[tgt_idx[1:0]] : 8'h00;
            end else begin
                tgt_sr = {tgt_sr[6:0], 1'b0};
            end
        end
    end

    int cs_hi_len = 0;
    int last_cs_hi = 0;
    always @(negedge clk) begin
        if (a_cs_n === 1'b1) begin
            cs_hi_len = cs_hi_len + 1;
        end else if (cs_hi_len != 0) begin
            last_cs_hi = cs_hi_len;
            cs_hi_len  = 0;
        end
    end

    function automatic logic [7:0] mosi_byte(input int b);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++)
            if (b * 8 + i < obs_mosi.size()) v = {v[6:0], obs_mosi[b * 8 + i]};
        return v;
    endfunction

    task automatic run_a(input int len, input bit hammer, input int budget);
        int   cyc;
        logic prev_sclk, prev_cs;
        bit   fin;
        obs_rx.delete();
        obs_mosi.delete();
        r_lat = -1; r_tx = 0; r_rises = 0; r_cs_rise = 0;
        @(negedge clk);
        a_tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
        a_len     = len[LW-1:0];
        a_start   = 1'b1;
        cyc = 0; fin = 1'b0;
        prev_sclk = a_sclk; prev_cs = a_cs_n;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (a_tx_ready) begin
                r_tx++;
                if (tx_src.size() > 0) void'(tx_src.pop_front());
                a_tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
            end
            if (a_rd_valid) obs_rx.push_back(a_rd_data);
            if (a_sclk && !prev_sclk) begin
                r_rises++;
                obs_mosi.push_back(a_mosi);
            end
            if (a_cs_n && !prev_cs) r_cs_rise++;
            prev_sclk = a_sclk;
            prev_cs   = a_cs_n;
            if (a_done) begin
                fin   = 1'b1;
                r_lat = cyc;
            end
            a_start = hammer && !fin;
        end
        a_start = 1'b0;
    endtask

    task automatic clear_sb;
        tx_src.delete();
        exp_rx.delete();
        exp_tx.delete();
    endtask

    task automatic test_reset;
        logic [16:0] got;
        reset = 1'b1;
        a_start = 1'b0; a_len = '0; a_tx_data = 8'h00; a_loop = 1'b1;
        b_start = 1'b0; b_len = '0; b_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        got = {a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_tx_ready, a_rd_valid, a_rd_data, 2'b00};
        n_tests++;
        if (got !== {1'b1, 6'b0, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values_held: got %b want %b", got, {1'b1, 6'b0, 8'h00, 2'b00});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        got = {a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_tx_ready, a_rd_valid, a_rd_data, 2'b00};
        n_tests++;
        if (got !== {1'b1, 6'b0, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values_released: got %b want %b", got, {1'b1, 6'b0, 8'h00, 2'b00});
        end
    endtask

    task automatic test_single;
        logic [7:0] e, g;
        clear_sb();
        a_loop = 1'b1;
        tx_src.push_back(8'hA5); exp_tx.push_back(8'hA5); exp_rx.push_back(8'hA5);
        run_a(1, 1'b0, 300);
        n_tests++;
        if (r_lat !== 1 + DA * 19) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want %0d", r_lat, 1 + DA * 19);
        end
        e = exp_tx.pop_front();
        g = mosi_byte(0);
        n_tests++;
        if (obs_mosi.size() !== 8 || g !== e) begin
            n_fail++;
            $display("FAIL single_mosi_bits: got %h (%0d bits) want %h", g, obs_mosi.size(), e);
        end
        e = exp_rx.pop_front();
        g = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL single_rd_data: got %h want %h", g, e);
        end
        n_tests++;
        if (r_tx !== 1 || obs_rx.size() !== 0) begin
            n_fail++;
            $display("FAIL single_pulse_count: got tx_ready %0d extra_rd %0d want 1 and 0", r_tx, obs_rx.size());
        end
    endtask

    task automatic test_multi_target;
        logic [7:0] e, g;
        int bad;
        clear_sb();
        a_loop = 1'b0;
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h5A;
        tx_src.push_back(8'h03); tx_src.push_back(8'h00); tx_src.push_back(8'h10);
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h00); exp_tx.push_back(8'h10);
        exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h5A);
        run_a(3, 1'b0, 400);
        n_tests++;
        if (r_lat !== 1 + DA * (3 + 16 * 3) || r_tx !== 3) begin
            n_fail++;
            $display("FAIL multi_latency_txready: got lat %0d tx %0d want %0d and 3", r_lat, r_tx, 1 + DA * 51);
        end
        n_tests++;
        if (r_rises !== 24 || r_cs_rise !== 1) begin
            n_fail++;
            $display("FAIL multi_sclk_cs: got rises %0d cs_rises %0d want 24 and 1", r_rises, r_cs_rise);
        end
        n_tests++;
        if (obs_rx.size() !== 3) begin
            n_fail++;
            $display("FAIL multi_rd_count: got %0d want 3", obs_rx.size());
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            e = exp_tx.pop_front();
            if (mosi_byte(i) !== e) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL multi_mosi_bytes: got %0d bad bytes want 0", bad);
        end
        bad = 0;
        g = 8'hxx;
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
            if (g !== e) bad++;
        end
        n_tests++;
        if (bad !== 0 || g !== 8'h5A) begin
            n_fail++;
            $display("FAIL multi_rd_data: got %0d bad, last %h want 0 bad, last 5a", bad, g);
        end
        a_loop = 1'b1;
    endtask

    task automatic test_zero_len;
        int viol;
        @(negedge clk);
        a_len = '0; a_start = 1'b1;
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_busy !== 1'b0 || a_cs_n !== 1'b1 || a_done !== 1'b0 || a_tx_ready !== 1'b0) viol++;
        end
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL zero_len_ignored: got %0d active cycles want 0", viol);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, g;
        int bad;
        clear_sb();
        a_loop = 1'b1;
        tx_src.push_back(8'h3C); tx_src.push_back(8'hC3);
        exp_rx.push_back(8'h3C); exp_rx.push_back(8'hC3);
        run_a(2, 1'b1, 400);
        n_tests++;
        if (r_lat !== 1 + DA * (3 + 32) || r_tx !== 2 || obs_rx.size() !== 2) begin
            n_fail++;
            $display("FAIL hammer_single_xfer: got lat %0d tx %0d rd %0d want %0d 2 2",
                     r_lat, r_tx, obs_rx.size(), 1 + DA * 35);
        end
        bad = 0;
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
            if (g !== e) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hammer_rd_data: got %0d bad want 0", bad);
        end
        tx_src.push_back(8'h7E); exp_rx.push_back(8'h7E);
        run_a(1, 1'b0, 300);
        e = exp_rx.pop_front();
        g = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
        n_tests++;
        if (r_lat !== 1 + DA * 19 || g !== e) begin
            n_fail++;
            $display("FAIL back_to_back_second: got lat %0d data %h want %0d %h", r_lat, g, 1 + DA * 19, e);
        end
        n_tests++;
        if (last_cs_hi < DA) begin
            n_fail++;
            $display("FAIL back_to_back_cs_gap: got %0d want >= %0d", last_cs_hi, DA);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] e, g;
        int viol;
        clear_sb();
        a_loop = 1'b1;
        for (int i = 0; i < 4; i++) tx_src.push_back(8'($urandom_range(0, 255)));
        // Cycle 91 lies in a high SCLK phase of the second byte
        run_a(4, 1'b0, 91);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({a_cs_n, a_sclk, a_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_async: got cs_n,sclk,busy %b want 100", {a_cs_n, a_sclk, a_busy});
        end
        n_tests++;
        if (r_lat !== -1 || obs_rx.size() !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_progress: got lat %0d rd %0d want -1 and 1", r_lat, obs_rx.size());
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_cs_n !== 1'b1) viol++;
        end
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d active cycles want 0", viol);
        end
        clear_sb();
        tx_src.push_back(8'h96); exp_rx.push_back(8'h96);
        run_a(1, 1'b0, 300);
        e = exp_rx.pop_front();
        g = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
        n_tests++;
        if (r_lat !== 1 + DA * 19 || g !== e) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got lat %0d data %h want %0d %h", r_lat, g, 1 + DA * 19, e);
        end
    endtask

    task automatic test_long_div2;
        logic [7:0] src[$];
        logic [7:0] exq[$];
        logic [7:0] e;
        int cyc, nrd, ntx, bad, lat, extra;
        bit fin;
        for (int i = 0; i < 255; i++) begin
            e = 8'($urandom_range(0, 255));
            src.push_back(e);
            exq.push_back(e);
        end
        @(negedge clk);
        b_tx_data = src[0];
        b_len     = 8'd255;
        b_start   = 1'b1;
        cyc = 0; nrd = 0; ntx = 0; bad = 0; lat = -1; fin = 1'b0;
        while (!fin && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            b_start = 1'b0;
            if (b_tx_ready) begin
                ntx++;
                if (src.size() > 0) void'(src.pop_front());
                b_tx_data = (src.size() > 0) ? src[0] : 8'h00;
            end
            if (b_rd_valid) begin
                nrd++;
                e = (exq.size() > 0) ? exq.pop_front() : 8'hxx;
                if (b_rd_data !== e) bad++;
            end
            if (b_done) begin
                fin = 1'b1;
                lat = cyc;
            end
        end
        n_tests++;
        if (lat !== 1 + DB * (3 + 16 * 255)) begin
            n_fail++;
            $display("FAIL long_latency: got %0d want %0d", lat, 1 + DB * (3 + 16 * 255));
        end
        n_tests++;
        if (nrd !== 255 || ntx !== 255 || bad !== 0) begin
            n_fail++;
            $display("FAIL long_bytes: got rd %0d tx %0d bad %0d want 255 255 0", nrd, ntx, bad);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_rd_valid || b_tx_ready || b_busy || b_done || !b_cs_n || b_sclk) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL long_terminates: got %0d active cycles after done want 0", extra);
        end
    endtask

    initial begin
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;
        test_reset();
        test_single();
        test_multi_target();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_long_div2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
